pool_out_writer: RTL and testbench

//  Write-back stage after the data rotator in the max-pool datapath: takes rotated pooled words and writes them to
//  the output global buffer (GBUFF_B) in row-major order at base + row*row_stride + col.

---
 rtl/pool_out_writer_pkg.sv | 14 +
 rtl/pool_out_fifo.sv | 48 ++++
 rtl/pool_out_writer.sv | 148 ++++++++++++++
 tb/tb_pool_out_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_out_writer_pkg.sv
// Shared word/address sizes and FSM encoding for the max-pool output writer.
package pool_out_writer_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int WORD_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    POW_ST_IDLE  = 2'd0,
    POW_ST_RUN   = 2'd1,
    POW_ST_DRAIN = 2'd2,
    POW_ST_DONE  = 2'd3
  } powState_t;

endpackage

// File: rtl/pool_out_fifo.sv
// Small synchronous skid FIFO; a push is accepted while full when a pop happens in the same cycle.
module pool_out_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_data;
  end

  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/pool_out_writer.sv
// Writes pooled words to GBUFF_B in row-major order through a skid FIFO.
// Optional POOL_OUT_CHKSUM_EN adds o_chksum, the XOR of every word written since start.
module pool_out_writer
  import pool_out_writer_pkg::*;
#(
  parameter int DATA_W     = WORD_SIZE,
  parameter int ADDR_W     = WORD_ADDR_BITS,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_out_dim,
  input  logic [CNT_W-1:0]  i_out_rows,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_row_stride,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_sram_req,
  input  logic              i_sram_gnt,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_di,
  output logic              o_busy,
  output logic              o_done,
`ifdef POOL_OUT_CHKSUM_EN
  output logic [DATA_W-1:0] o_chksum,
`endif
  output logic              o_err_ovf
);

  localparam int TOT_W = 2 * CNT_W;

  powState_t         r_state;
  powState_t         w_nextState;
  logic [CNT_W-1:0]  r_outDim;
  logic [CNT_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_rowStride;
  logic [ADDR_W-1:0] r_rowBase;
  logic [TOT_W-1:0]  r_total;
  logic [TOT_W-1:0]  r_accepted;
  logic [TOT_W-1:0]  r_written;
  logic              r_errOvf;

  logic              w_start;
  logic              w_active;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  assign w_start  = i_start && ((r_state == POW_ST_IDLE) || (r_state == POW_ST_DONE));
  assign w_active = (r_state == POW_ST_RUN) || (r_state == POW_ST_DRAIN);
  assign w_pop    = o_sram_req && i_sram_gnt;
  assign w_push   = i_in_valid && (r_state == POW_ST_RUN) && (r_accepted < r_total)
                    && (!w_full || w_pop);
  assign w_drop   = i_in_valid && w_active && !w_push;

  pool_out_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_in_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= POW_ST_IDLE;
    else      r_state <= w_nextState;
  end

  // A zero-sized job skips straight to DONE since nothing will ever be accepted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      POW_ST_IDLE, POW_ST_DONE: if (i_start) w_nextState = POW_ST_RUN;
      POW_ST_RUN: begin
        if (r_total == '0)                w_nextState = POW_ST_DONE;
        else if (r_accepted == r_total)   w_nextState = POW_ST_DRAIN;
      end
      POW_ST_DRAIN: if (w_empty && (r_written == r_accepted)) w_nextState = POW_ST_DONE;
      default: w_nextState = POW_ST_IDLE;
    endcase
  end

  // Row base advances by the stride at each row end, keeping multipliers out of the address path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outDim    <= '0;
      r_col       <= '0;
      r_rowStride <= '0;
      r_rowBase   <= '0;
      r_total     <= '0;
      r_accepted  <= '0;
      r_written   <= '0;
      r_errOvf    <= 1'b0;
    end else if (w_start) begin
      r_outDim    <= i_out_dim;
      r_col       <= '0;
      r_rowStride <= i_row_stride;
      r_rowBase   <= i_base_addr;
      r_total     <= TOT_W'(i_out_dim) * TOT_W'(i_out_rows);
      r_accepted  <= '0;
      r_written   <= '0;
      r_errOvf    <= 1'b0;
    end else begin
      if (w_push) r_accepted <= r_accepted + TOT_W'(1);
      if (w_pop) begin
        r_written <= r_written + TOT_W'(1);
        if (r_col == r_outDim - CNT_W'(1)) begin
          r_col     <= '0;
          r_rowBase <= r_rowBase + r_rowStride;
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end
      if (w_drop) r_errOvf <= 1'b1;
    end
  end

`ifdef POOL_OUT_CHKSUM_EN
  logic [DATA_W-1:0] r_chksum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_chksum <= '0;
    else if (w_start) r_chksum <= '0;
    else if (w_pop)   r_chksum <= r_chksum ^ w_head;
  end

  assign o_chksum = r_chksum;
`endif

  assign o_sram_req  = w_active && !w_empty;
  assign o_sram_addr = r_rowBase + ADDR_W'(r_col);
  assign o_sram_di   = w_head;
  assign o_busy      = w_active;
  assign o_done      = (r_state == POW_ST_DONE);
  assign o_err_ovf   = r_errOvf;

endmodule

// File: tb/tb_pool_out_writer.sv
// Randomized self-checking bench for pool_out_writer against a queue-based reference model.
// Chksum checks are compiled in when POOL_OUT_CHKSUM_EN is defined.
module tb_pool_out_writer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 10;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic [CNT_W-1:0]  i_out_dim = '0;
  logic [CNT_W-1:0]  i_out_rows = '0;
  logic [ADDR_W-1:0] i_base_addr = '0;
  logic [ADDR_W-1:0] i_row_stride = '0;
  logic              i_in_valid = 1'b0;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_sram_req;
  logic              i_sram_gnt = 1'b1;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_di;
  logic              o_busy;
  logic              o_done;
  logic              o_err_ovf;
`ifdef POOL_OUT_CHKSUM_EN
  logic [DATA_W-1:0] o_chksum;
`endif

  pool_out_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_out_dim    (i_out_dim),
    .i_out_rows   (i_out_rows),
    .i_base_addr  (i_base_addr),
    .i_row_stride (i_row_stride),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_sram_req   (o_sram_req),
    .i_sram_gnt   (i_sram_gnt),
    .o_sram_addr  (o_sram_addr),
    .o_sram_di    (o_sram_di),
    .o_busy       (o_busy),
    .o_done       (o_done),
`ifdef POOL_OUT_CHKSUM_EN
    .o_chksum     (o_chksum),
`endif
    .o_err_ovf    (o_err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending words, accepted/written counts, sticky error and running XOR.
  logic [DATA_W-1:0] mdlQ[$];
  logic [ADDR_W-1:0] wrLog[$];
  logic [ADDR_W-1:0] expLog[$];
  bit          mdlActive = 1'b0;
  bit          mdlErr = 1'b0;
  int          mdlAcc = 0;
  int          mdlTotal = 0;
  int          mdlK = 0;
  int          mdlDim = 0;
  int unsigned mdlBase = 0;
  int unsigned mdlStride = 0;
  logic [DATA_W-1:0] mdlChk = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdlQ.delete();
      mdlActive = 1'b0;
      mdlErr    = 1'b0;
      mdlAcc    = 0;
      mdlK      = 0;
      mdlChk    = '0;
    end else if (mdlActive) begin
      bit pop;
      bit push;
      pop  = (mdlQ.size() != 0) && i_sram_gnt;
      push = 1'b0;
      if (i_in_valid) begin
        if (mdlAcc < mdlTotal && (mdlQ.size() < DEPTH || pop)) push = 1'b1;
        else mdlErr = 1'b1;
      end
      if (pop) begin
        mdlChk = mdlChk ^ mdlQ[0];
        void'(mdlQ.pop_front());
        mdlK++;
      end
      if (push) begin
        mdlQ.push_back(i_in_data);
        mdlAcc++;
      end
      if (mdlAcc == mdlTotal && mdlQ.size() == 0) mdlActive = 1'b0;
    end else if (i_start) begin
      mdlActive = 1'b1;
      mdlDim    = int'(i_out_dim);
      mdlTotal  = int'(i_out_dim) * int'(i_out_rows);
      mdlBase   = int'(i_base_addr);
      mdlStride = int'(i_row_stride);
      mdlAcc    = 0;
      mdlK      = 0;
      mdlErr    = 1'b0;
      mdlChk    = '0;
      mdlQ.delete();
    end
  end

  always @(posedge clk) begin
    if (rst && o_sram_req && i_sram_gnt) wrLog.push_back(o_sram_addr);
  end

  // Every cycle: request, head address/data and sticky error must match the model.
  always @(negedge clk) begin
    checkOutput("errOvf", 32'(o_err_ovf), 32'(mdlErr));
    if (mdlQ.size() != 0) begin
      logic [ADDR_W-1:0] expAddr;
      expAddr = ADDR_W'(mdlBase + (mdlK / mdlDim) * mdlStride + (mdlK % mdlDim));
      checkOutput("sramReq", 32'(o_sram_req), 32'd1);
      checkOutput("sramAddr", 32'(o_sram_addr), 32'(expAddr));
      checkOutput("sramData", 32'(o_sram_di), 32'(mdlQ[0]));
    end else begin
      checkOutput("sramReqIdle", 32'(o_sram_req), 32'd0);
    end
  end

  task automatic applyStimulus(input int dim, input int rows, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W-1:0] stride, input int lowStart, input int lowLen,
                               input bit rnd, input bit extra, input logic [DATA_W-1:0] dataSeed);
    int cyc;
    int word;
    bit extraDone;
    cyc = 0;
    word = 0;
    extraDone = 1'b0;
    @(negedge clk);
    i_out_dim    = CNT_W'(dim);
    i_out_rows   = CNT_W'(rows);
    i_base_addr  = base;
    i_row_stride = stride;
    i_start      = 1'b1;
    wrLog.delete();
    @(negedge clk);
    i_start = 1'b0;
    while (!o_done && cyc < BUDGET) begin
      i_sram_gnt = rnd ? ($urandom % 4 != 0) : 1'b1;
      if (cyc >= lowStart && cyc < lowStart + lowLen) i_sram_gnt = 1'b0;
      i_in_valid = (mdlAcc < mdlTotal) && (rnd ? ($urandom % 3 != 0) : 1'b1);
      if (extra && !extraDone && mdlAcc == mdlTotal && mdlQ.size() != 0) begin
        i_in_valid = 1'b1;
        i_sram_gnt = 1'b0;
        extraDone  = 1'b1;
      end
      i_in_data = rnd ? DATA_W'($urandom) : dataSeed + DATA_W'(word);
      if (i_in_valid) word++;
      @(negedge clk);
      cyc++;
    end
    i_in_valid = 1'b0;
    i_sram_gnt = 1'b1;
    checkOutput("doneReached", 32'(o_done), 32'd1);
    checkOutput("busyAtDone", 32'(o_busy), 32'd0);
    checkOutput("writeCount", 32'(wrLog.size()), 32'(mdlTotal));
`ifdef POOL_OUT_CHKSUM_EN
    checkOutput("chksum", 32'(o_chksum), 32'(mdlChk));
`endif
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "Len"}, 32'(wrLog.size()), 32'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < wrLog.size(); i++)
      checkOutput(name, 32'(wrLog[i]), 32'(expLog[i]));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rstReq", 32'(o_sram_req), 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstErr", 32'(o_err_ovf), 32'd0);
    rst = 1'b1;

    // Straight job, then one with a three-cycle grant gap.
    expLog = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h20, 16'h21, 16'h22, 16'h23};
    applyStimulus(4, 2, 16'h0010, 16'd16, 0, 0, 1'b0, 1'b0, 16'h0100);
    checkLog("job1Addr");
    checkOutput("job1Err", 32'(o_err_ovf), 32'd0);
    applyStimulus(4, 2, 16'h0010, 16'd16, 3, 3, 1'b0, 1'b0, 16'h0200);
    checkLog("job2Addr");
    checkOutput("job2Err", 32'(o_err_ovf), 32'd0);

    // Six cycles without grant overflow the four-entry FIFO.
    applyStimulus(4, 2, 16'h0010, 16'd16, 0, 6, 1'b0, 1'b0, 16'h0300);
    checkOutput("job3Err", 32'(o_err_ovf), 32'd1);
    checkOutput("job3Writes", 32'(wrLog.size()), 32'd8);

    // Zero-row job, then words arriving while DONE.
    applyStimulus(4, 0, 16'h0010, 16'd16, 0, 0, 1'b0, 1'b0, 16'h0400);
    for (int i = 0; i < 3; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = 16'hBEEF;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("zeroJobWrites", 32'(wrLog.size()), 32'd0);
    checkOutput("zeroJobErr", 32'(o_err_ovf), 32'd0);
    checkOutput("zeroJobDone", 32'(o_done), 32'd1);

    expLog = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    applyStimulus(4, 1, 16'hFFFE, 16'd0, 0, 0, 1'b0, 1'b0, 16'h0500);
    checkLog("wrapAddr");

    // Reset mid-run with two words queued.
    @(negedge clk);
    i_out_dim = 10'd4; i_out_rows = 10'd2; i_base_addr = 16'h0080; i_row_stride = 16'd8;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_sram_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = 16'h1234 + 16'(i);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("queuedReq", 32'(o_sram_req), 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReq", 32'(o_sram_req), 32'd0);
    checkOutput("midRstBusy", 32'(o_busy), 32'd0);
    checkOutput("midRstDone", 32'(o_done), 32'd0);
    rst = 1'b1;
    i_sram_gnt = 1'b1;
    expLog = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
    applyStimulus(4, 1, 16'h0040, 16'd0, 0, 0, 1'b0, 1'b0, 16'h00A5);
    checkLog("postRstAddr");
`ifdef POOL_OUT_CHKSUM_EN
    checkOutput("postRstChksum", 32'(o_chksum), 32'h000C);
`endif

    // Randomized jobs with random grant, valid gaps and occasional excess words.
    for (int j = 0; j < 12; j++) begin
      applyStimulus($urandom_range(1, 5), $urandom_range(1, 3), ADDR_W'($urandom), ADDR_W'($urandom),
                    0, 0, 1'b1, 1'($urandom % 2), '0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
